// File: rtl/calc_pkg.sv
// Shared definitions for the 4-op calculator and its host driver:
// operand width, result-width helpers and host FSM state encodings.
package calc_pkg;

    localparam int CALC_DW = 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    function automatic int add_w(input int dw);
        return dw + 1;
    endfunction

    function automatic int mul_w(input int dw);
        return 2 * dw;
    endfunction

endpackage

// File: rtl/calc_alu.sv
// Registered 4-op calculator: add/sub/mul/div of two unsigned operands,
// results valid one clock after the operands change.
module calc_alu
    import calc_pkg::*;
#(
    parameter int DW = CALC_DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DW-1:0]         i_data1,
    input  logic [DW-1:0]         i_data2,
    output logic [add_w(DW)-1:0]  o_add,
    output logic [add_w(DW)-1:0]  o_sub,
    output logic [mul_w(DW)-1:0]  o_mul,
    output logic [DW-1:0]         o_div
);

    localparam int AW = add_w(DW);
    localparam int MW = mul_w(DW);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_add <= '0;
            o_sub <= '0;
            o_mul <= '0;
            o_div <= '0;
        end else begin
            o_add <= AW'(i_data1) + AW'(i_data2);
            o_sub <= AW'(i_data1) - AW'(i_data2);
            o_mul <= MW'(i_data1) * MW'(i_data2);
            // A zero divisor yields 0 here; the host substitutes its own marker.
            o_div <= (i_data2 == '0) ? '0 : i_data1 / i_data2;
        end
    end

endmodule

// File: rtl/calc_host.sv
// Host-side driver for the registered calculator: accepts one operand pair,
// waits out the calculator latency, captures all four results and returns them.
module calc_host
    import calc_pkg::*;
#(
    parameter int DW       = CALC_DW,
    parameter int CALC_LAT = 1,
    parameter int CW       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [DW-1:0]         i_req_a,
    input  logic [DW-1:0]         i_req_b,
    output logic [DW-1:0]         o_calc_data1,
    output logic [DW-1:0]         o_calc_data2,
    input  logic [add_w(DW)-1:0]  i_calc_add,
    input  logic [add_w(DW)-1:0]  i_calc_sub,
    input  logic [mul_w(DW)-1:0]  i_calc_mul,
    input  logic [DW-1:0]         i_calc_div,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [add_w(DW)-1:0]  o_rsp_add,
    output logic [add_w(DW)-1:0]  o_rsp_sub,
    output logic [mul_w(DW)-1:0]  o_rsp_mul,
    output logic [DW-1:0]         o_rsp_div,
    output logic                  o_rsp_dbz,
    output logic                  o_rsp_neg,
    output logic [CW-1:0]         o_txn_cnt
);

    localparam int LW = $clog2(CALC_LAT + 1);

    logic [1:0]    state;
    logic [LW-1:0] wait_cnt;
    logic          dbz;

    // NOTE: all state below uses non-blocking assignments so each register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            dbz          <= 1'b0;
            o_calc_data1 <= '0;
            o_calc_data2 <= '0;
            o_rsp_add    <= '0;
            o_rsp_sub    <= '0;
            o_rsp_mul    <= '0;
            o_rsp_div    <= '0;
            o_rsp_dbz    <= 1'b0;
            o_rsp_neg    <= 1'b0;
            o_txn_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Operand registers are only loaded here, so they hold between transactions.
                    if (i_req_valid) begin
                        o_calc_data1 <= i_req_a;
                        o_calc_data2 <= i_req_b;
                        dbz          <= (i_req_b == '0);
                        wait_cnt     <= LW'(CALC_LAT - 1);
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) state <= S_CAPT;
                    else                wait_cnt <= wait_cnt - LW'(1);
                end
                S_CAPT: begin
                    o_rsp_add <= i_calc_add;
                    o_rsp_sub <= i_calc_sub;
                    o_rsp_mul <= i_calc_mul;
                    o_rsp_div <= dbz ? '1 : i_calc_div;
                    o_rsp_dbz <= dbz;
                    o_rsp_neg <= i_calc_sub[DW];
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        o_txn_cnt <= o_txn_cnt + CW'(1);
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready = (state == S_IDLE);
    assign o_rsp_valid = (state == S_RESP);

endmodule
